i2s_rx_frame_ctrl: RTL and testbench
====================================

Name: i2s_rx_frame_ctrl

Overview:
I2S master-mode receive controller for the simaudio FPGA. Derives I2S_BCLK_OUT and I2S_WCLK_OUT from MCLK_IN and sequences deserialisation of two I2S data lines (I2S_din0, I2S_din1) into parallel stereo frames. Completed frames go to downstream (USB/dout) logic through a valid/ack handshake. Sits between the ADC I2S pins and the sample-processing datapath.

Parameters:
WIDTH, 24, captured sample bits per channel, MSB first; must satisfy WIDTH <= SLOT_BITS-1.
SLOT_BITS, 32, BCLK periods per channel slot; frame = 2*SLOT_BITS BCLK periods.
BCLK_DIV, 4, MCLK_IN cycles per BCLK period; even, >= 2.

Ports:
MCLK_IN  in  1  sole clock; all logic on its rising edge.
RST_IN  in  1  synchronous, active-high reset.
ENABLE_IN  in  1  run request; sampled each MCLK cycle.
I2S_din0  in  1  serial data line 0.
I2S_din1  in  1  serial data line 1.
I2S_BCLK_OUT  out  1  bit clock (registered).
I2S_WCLK_OUT  out  1  word clock: 0 = left slot, 1 = right slot (registered).
FRAME_VALID_OUT  out  1  frame registers hold an unconsumed frame.
FRAME_ACK_IN  in  1  consumer accepts the frame when high while FRAME_VALID_OUT is high.
L0_OUT, R0_OUT, L1_OUT, R1_OUT  out  WIDTH each  left/right samples from din0/din1.
OVERRUN_OUT  out  1  sticky: a completed frame was dropped.
OVERRUN_CLR_IN  in  1  clears OVERRUN_OUT.
RUNNING_OUT  out  1  high while clocks are being generated.

Behaviour:
- Reset: all outputs 0; div_cnt=0, bit_cnt=0; state IDLE. Reset mid-frame abandons the partial frame without asserting valid.
- States: IDLE (BCLK=0, WCLK=0, counters held at 0); RUN; DRAIN. IDLE->RUN on the cycle ENABLE_IN=1. RUN->DRAIN when ENABLE_IN=0. DRAIN->RUN if ENABLE_IN returns to 1 before the frame ends. DRAIN->IDLE when the last BCLK period of the frame ends (bit_cnt=2*SLOT_BITS-1, div_cnt=BCLK_DIV-1). RUNNING_OUT = (state != IDLE).
- Divider: div_cnt counts 0..BCLK_DIV-1 in RUN/DRAIN. BCLK_OUT=0 for div_cnt < BCLK_DIV/2, else 1, registered.
- Rise event: the cycle BCLK_OUT goes 0->1. Fall event: the cycle it goes 1->0.
- bit_cnt (0..2*SLOT_BITS-1) increments on each fall event and wraps to 0. WCLK_OUT = (bit_cnt >= SLOT_BITS), registered, so WCLK changes coincident with BCLK falling.
- First frame after IDLE starts at bit_cnt=0 (left slot) with BCLK low for BCLK_DIV/2 cycles.
- Slot position p = bit_cnt mod SLOT_BITS. I2S one-bit delay: at the rise event in position p, 1<=p<=WIDTH, both din lines are sampled into sample bit WIDTH-p (MSB at p=1). Samples at p=0 or p>WIDTH are ignored.
- Frame complete: on the rise event at right slot position p=WIDTH.
  - If FRAME_VALID_OUT=0 (or acked in this same cycle), transfer the four shift registers to the output registers and set FRAME_VALID_OUT on the next cycle.
  - Otherwise drop the frame, leave the outputs unchanged, and set OVERRUN_OUT.
- Handshake: FRAME_VALID_OUT clears the cycle after FRAME_VALID_OUT && FRAME_ACK_IN. Ack and a new completion in the same cycle: the new frame loads, valid stays 1, no overrun. ACK while not valid is ignored.
- OVERRUN_OUT: set has priority over OVERRUN_CLR_IN in the same cycle. Cleared only by clear or reset.
- Output samples are stable while FRAME_VALID_OUT=1.

Test Plan:
1. Reset/idle: RST_IN=1 for 3 cycles, ENABLE_IN=0 -> BCLK, WCLK, FRAME_VALID_OUT, OVERRUN_OUT and RUNNING_OUT all 0 for 100 cycles.
2. Clock timing (BCLK_DIV=4, SLOT_BITS=32): enable -> BCLK period 4 MCLK, 50% duty; WCLK period 256 MCLK; WCLK toggles only on BCLK falling edges; first WCLK rise after 128 MCLK.
3. Capture: drive L0=24'h800001, R0=24'h7FFFFE, L1=24'hA5A5A5, R1=24'h5A5A5A in I2S format (MSB one BCLK after WCLK edge) -> FRAME_VALID_OUT with exact values. Garbage on bits at p=0 and p>24 has no effect.
4. Handshake/overrun: never ack -> second frame dropped, OVERRUN_OUT=1, outputs keep the first frame. Ack -> valid drops next cycle. Ack coincident with completion -> no overrun. OVERRUN_CLR_IN clears the flag.
5. Drain: deassert ENABLE_IN mid-left slot -> frame completes and is delivered, then IDLE with BCLK=0 after bit_cnt 63. Re-enable during DRAIN -> no gap in BCLK.
6. Reset mid-frame at right slot p=10 -> all outputs 0 next cycle, no FRAME_VALID_OUT, next enable restarts at left slot.

Source files
------------

// File: rtl/i2s_rx_frame_ctrl.sv
// I2S master-mode receive controller: derives BCLK/WCLK from MCLK and
// deserialises two stereo data lines into parallel frames with a valid/ack handshake.
`timescale 1ns/1ps
module i2s_rx_frame_ctrl #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic             MCLK_IN,
  input  logic             RST_IN,
  input  logic             ENABLE_IN,
  input  logic             I2S_din0,
  input  logic             I2S_din1,
  output logic             I2S_BCLK_OUT,
  output logic             I2S_WCLK_OUT,
  output logic             FRAME_VALID_OUT,
  input  logic             FRAME_ACK_IN,
  output logic [WIDTH-1:0] L0_OUT,
  output logic [WIDTH-1:0] R0_OUT,
  output logic [WIDTH-1:0] L1_OUT,
  output logic [WIDTH-1:0] R1_OUT,
  output logic             OVERRUN_OUT,
  input  logic             OVERRUN_CLR_IN,
  output logic             RUNNING_OUT
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_N   = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [CNT_W-1:0] bit_cnt, bit_nx, pos;
  logic             active, rise_ev, fall_ev, right_slot;
  logic             capture_ev, frame_done, load_ok;
  logic [WIDTH-1:0] l0_sh, r0_sh, l1_sh, r1_sh;
  logic [WIDTH-1:0] l0_nx, r0_nx, l1_nx, r1_nx;

  always_comb begin
    active     = (state != IDLE);
    rise_ev    = active && (div_cnt == DIV_RISE);
    fall_ev    = active && (div_cnt == DIV_LAST);
    right_slot = (bit_cnt >= SLOT_N);
    pos        = right_slot ? (bit_cnt - SLOT_N) : bit_cnt;
    capture_ev = rise_ev && (pos != '0) && (pos <= POS_LAST);
    frame_done = rise_ev && right_slot && (pos == POS_LAST);
    load_ok    = !FRAME_VALID_OUT || FRAME_ACK_IN;

    div_nx = '0;
    bit_nx = '0;
    if (active) begin
      div_nx = fall_ev ? '0 : div_cnt + 1'b1;
      bit_nx = bit_cnt;
      if (fall_ev) bit_nx = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end

    // Slot position p lands in sample bit WIDTH-p; the next-value view lets the
    // final LSB captured on the completion edge go straight into the outputs.
    l0_nx = l0_sh;
    r0_nx = r0_sh;
    l1_nx = l1_sh;
    r1_nx = r1_sh;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (capture_ev && (pos == CNT_W'(WIDTH - i))) begin
        if (right_slot) begin
          r0_nx[i] = I2S_din0;
          r1_nx[i] = I2S_din1;
        end else begin
          l0_nx[i] = I2S_din0;
          l1_nx[i] = I2S_din1;
        end
      end
    end

    state_nx = state;
    case (state)
      IDLE:    if (ENABLE_IN) state_nx = RUN;
      RUN:     if (!ENABLE_IN) state_nx = DRAIN;
      DRAIN: begin
        if (ENABLE_IN)                         state_nx = RUN;
        else if (fall_ev && bit_cnt == BIT_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge MCLK_IN) begin
    if (RST_IN) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      I2S_BCLK_OUT    <= 1'b0;
      I2S_WCLK_OUT    <= 1'b0;
      l0_sh           <= '0;
      r0_sh           <= '0;
      l1_sh           <= '0;
      r1_sh           <= '0;
      L0_OUT          <= '0;
      R0_OUT          <= '0;
      L1_OUT          <= '0;
      R1_OUT          <= '0;
      FRAME_VALID_OUT <= 1'b0;
      OVERRUN_OUT     <= 1'b0;
    end else begin
      state        <= state_nx;
      div_cnt      <= div_nx;
      bit_cnt      <= bit_nx;
      I2S_BCLK_OUT <= (div_nx >= DIV_HALF);
      I2S_WCLK_OUT <= (bit_nx >= SLOT_N);
      l0_sh        <= l0_nx;
      r0_sh        <= r0_nx;
      l1_sh        <= l1_nx;
      r1_sh        <= r1_nx;

      if (frame_done && load_ok) begin
        L0_OUT          <= l0_nx;
        R0_OUT          <= r0_nx;
        L1_OUT          <= l1_nx;
        R1_OUT          <= r1_nx;
        FRAME_VALID_OUT <= 1'b1;
      end else if (FRAME_VALID_OUT && FRAME_ACK_IN) begin
        FRAME_VALID_OUT <= 1'b0;
      end

      if (frame_done && !load_ok) OVERRUN_OUT <= 1'b1;
      else if (OVERRUN_CLR_IN)    OVERRUN_OUT <= 1'b0;
    end
  end

  assign RUNNING_OUT = (state != IDLE);

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl (WIDTH=24, SLOT_BITS=32, BCLK_DIV=4);
// cycle k counts MCLK cycles from the first RUN cycle of each enable.
`timescale 1ns/1ps
module tb_i2s_rx_frame_ctrl;

  logic        mclk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, ack = 1'b0, ovr_clr = 1'b0;
  logic        din0 = 1'b0, din1 = 1'b0;
  logic        bclk, wclk, valid, ovr, running;
  logic [23:0] l0, r0, l1, r1;
  logic [23:0] f_l0 = '0, f_r0 = '0, f_l1 = '0, f_r1 = '0;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 mclk = ~mclk;

  i2s_rx_frame_ctrl #(.WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
    .MCLK_IN(mclk), .RST_IN(rst), .ENABLE_IN(en),
    .I2S_din0(din0), .I2S_din1(din1),
    .I2S_BCLK_OUT(bclk), .I2S_WCLK_OUT(wclk),
    .FRAME_VALID_OUT(valid), .FRAME_ACK_IN(ack),
    .L0_OUT(l0), .R0_OUT(r0), .L1_OUT(l1), .R1_OUT(r1),
    .OVERRUN_OUT(ovr), .OVERRUN_CLR_IN(ovr_clr), .RUNNING_OUT(running)
  );

  // Serial source: tracks its own bit position from BCLK falls and drives
  // the current frame values MSB first one BCLK after each slot boundary.
  int   tb_bit = 0;
  int   p;
  logic prev_b = 1'b0;
  always @(posedge mclk) begin
    #1;
    if (running !== 1'b1) tb_bit = 0;
    else if (prev_b === 1'b1 && bclk === 1'b0) tb_bit = (tb_bit + 1) % 64;
    prev_b = bclk;
    p = tb_bit % 32;
    if (p >= 1 && p <= 24) begin
      if (tb_bit >= 32) begin
        din0 = f_r0[24-p];
        din1 = f_r1[24-p];
      end else begin
        din0 = f_l0[24-p];
        din1 = f_l1[24-p];
      end
    end else begin
      din0 = 1'($urandom_range(0, 1));
      din1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
    k++;
  endtask

  task automatic go_to(input int target);
    while (k < target) step();
  endtask

  task automatic set_frame(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input logic [23:0] d);
    f_l0 = a; f_r0 = b; f_l1 = c; f_r1 = d;
  endtask

  task automatic check_frame(input string tag, input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] c, input logic [23:0] d);
    check({tag, "_l0"}, l0, a);
    check({tag, "_r0"}, r0, b);
    check({tag, "_l1"}, l1, c);
    check({tag, "_r1"}, r1, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seen;
    int errs_b, errs_w, first_w, first_v;
    logic pb, pw;

    // Reset and idle
    repeat (3) @(posedge mclk);
    #1;
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 100; i++) begin
      seen |= {bclk, wclk, valid, ovr, running};
      step();
    end
    check("idle_outputs", 32'(seen), 0);
    check("idle_l0", l0, 0);

    // Frame 1: clock timing and capture
    set_frame(24'h800001, 24'h7FFFFE, 24'hA5A5A5, 24'h5A5A5A);
    en = 1'b1;
    step();
    k = 0;
    check("running_on", running, 1);
    errs_b = 0; errs_w = 0; first_w = -1; first_v = -1;
    pb = 1'b0; pw = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (bclk !== ((k % 4) >= 2)) errs_b++;
      if (wclk !== (((k / 4) % 64) >= 32)) errs_w++;
      if (k > 0 && wclk !== pw && !(pb === 1'b1 && bclk === 1'b0)) errs_w++;
      if (wclk === 1'b1 && first_w < 0) first_w = k;
      if (valid === 1'b1 && first_v < 0) first_v = k;
      pb = bclk; pw = wclk;
      step();
    end
    check("bclk_pattern", errs_b, 0);
    check("wclk_pattern", errs_w, 0);
    check("wclk_first_rise", first_w, 128);
    check("valid_first", first_v, 226);
    check_frame("f1", 24'h800001, 24'h7FFFFE, 24'hA5A5A5, 24'h5A5A5A);
    check("f1_ovr", ovr, 0);

    // Frame 2 never acked: dropped, overrun set even with clear held
    set_frame(24'h123456, 24'hFEDCBA, 24'h000000, 24'hFFFFFF);
    go_to(470);
    ovr_clr = 1'b1;
    go_to(482);
    ovr_clr = 1'b0;
    check("ovr_set_beats_clr", ovr, 1);
    check("f2_valid_held", valid, 1);
    check_frame("f2_keep", 24'h800001, 24'h7FFFFE, 24'hA5A5A5, 24'h5A5A5A);
    go_to(490);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clr", ovr, 0);

    go_to(500);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_drop", valid, 0);
    go_to(510);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("ack_not_valid", {valid, ovr}, 0);

    // Frame 3 into empty registers
    go_to(512);
    set_frame(24'h0F0F0F, 24'hF0F0F0, 24'h000001, 24'h800000);
    go_to(737);
    check("f3_pre_valid", valid, 0);
    step();
    check("f3_valid", valid, 1);
    check_frame("f3", 24'h0F0F0F, 24'hF0F0F0, 24'h000001, 24'h800000);
    check("f3_ovr", ovr, 0);

    // Frame 4 completes in the same cycle frame 3 is acked
    go_to(768);
    set_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    go_to(993);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("f4_valid", valid, 1);
    check_frame("f4", 24'h111111, 24'h222222, 24'h333333, 24'h444444);
    check("f4_no_ovr", ovr, 0);
    go_to(1000);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Frame 5: enable dropped mid left slot, frame still delivered
    go_to(1024);
    set_frame(24'hABCDEF, 24'h13579B, 24'h2468AC, 24'hFFFFFE);
    go_to(1064);
    en = 1'b0;
    go_to(1250);
    check("f5_valid", valid, 1);
    check_frame("f5", 24'hABCDEF, 24'h13579B, 24'h2468AC, 24'hFFFFFE);
    go_to(1279);
    check("drain_last_bit", {running, bclk, wclk}, 3'b111);
    step();
    check("drain_idle", {running, bclk, wclk}, 0);
    go_to(1290);
    check("drain_stays_idle", {running, bclk}, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Re-enable during drain keeps BCLK continuous
    set_frame(24'hC0FFEE, 24'hBADA55, 24'h0DDBA1, 24'h1CE1CE);
    en = 1'b1;
    step();
    k = 0;
    errs_b = 0;
    for (int i = 0; i < 300; i++) begin
      if (k == 20) en = 1'b0;
      if (k == 30) en = 1'b1;
      if (bclk !== ((k % 4) >= 2) || running !== 1'b1) errs_b++;
      step();
    end
    check("redrain_bclk", errs_b, 0);
    check_frame("f6", 24'hC0FFEE, 24'hBADA55, 24'h0DDBA1, 24'h1CE1CE);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Reset at right slot p=10
    go_to(425);
    check("pre_rst_wclk", wclk, 1);
    rst = 1'b1;
    en = 1'b0;
    step();
    rst = 1'b0;
    check("rst_ctl", {bclk, wclk, valid, ovr, running}, 0);
    check_frame("rst", 24'h0, 24'h0, 24'h0, 24'h0);
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      seen |= {bclk, wclk, valid, ovr, running};
      step();
    end
    check("rst_idle", 32'(seen), 0);

    // Restart begins in the left slot
    set_frame(24'h654321, 24'h0FEDCB, 24'h7FFFFF, 24'h800000);
    en = 1'b1;
    step();
    k = 0;
    go_to(127);
    check("restart_left", wclk, 0);
    step();
    check("restart_right", wclk, 1);
    go_to(226);
    check("f8_valid", valid, 1);
    check_frame("f8", 24'h654321, 24'h0FEDCB, 24'h7FFFFF, 24'h800000);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
